vga_scanout: RTL



---
 rtl/vga_scanout.sv | 112 +++++++++++
 1 files changed

// File: rtl/vga_scanout.sv
// Raster engine: scans the 160x120 framebuffer with 4x4 pixel replication and
// drives 640x480@60 VGA timing from the 50 MHz clock (25 MHz pixel rate).
module vga_scanout #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int FB_W     = 160
) (
  input  logic        clock,
  input  logic        reset,
  output logic [14:0] fb_addr,
  output logic        fb_rd,
  input  logic [2:0]  fb_data,
  output logic [9:0]  VGA_R,
  output logic [9:0]  VGA_G,
  output logic [9:0]  VGA_B,
  output logic        VGA_HS,
  output logic        VGA_VS,
  output logic        VGA_BLANK_N,
  output logic        VGA_SYNC_N,
  output logic        VGA_CLK,
  output logic        frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [14:0]   FB_MUL = 15'(FB_W);

  logic          ph;
  logic          pix_en;
  logic [HW-1:0] hc;
  logic [VW-1:0] vc;
  logic          h_act, v_act, hs_n, vs_n;
  logic [14:0]   px, py, addr_nxt;
  // vld_pipe[1]: stage-1 active (read issued), vld_pipe[2]: pin-stage active
  logic [2:1]    vld_pipe;
  logic          hs1, vs1;

  assign pix_en = ph;
  assign h_act  = hc < H_ACT;
  assign v_act  = vc < V_ACT;
  assign hs_n   = !(hc >= HS_BEG && hc < HS_END);
  assign vs_n   = !(vc >= VS_BEG && vc < VS_END);

  // Scale shift of 2 gives the 4x4 replication; constant multiply folds to shifts
  assign px       = 15'(hc >> 2);
  assign py       = 15'(vc >> 2);
  assign addr_nxt = py * FB_MUL + px;

  always_ff @(posedge clock) begin
    if (reset) begin
      ph          <= 1'b0;
      hc          <= '0;
      vc          <= '0;
      fb_addr     <= '0;
      vld_pipe    <= '0;
      hs1         <= 1'b1;
      vs1         <= 1'b1;
      VGA_HS      <= 1'b1;
      VGA_VS      <= 1'b1;
      VGA_R       <= '0;
      VGA_G       <= '0;
      VGA_B       <= '0;
      frame_start <= 1'b0;
    end else begin
      ph          <= ~ph;
      frame_start <= pix_en && (hc == '0) && (vc == '0);
      if (pix_en) begin
        if (hc == H_LAST) begin
          hc <= '0;
          vc <= (vc == V_LAST) ? '0 : vc + 1'b1;
        end else begin
          hc <= hc + 1'b1;
        end
        // stage 1: address and raw syncs; address holds through blanking
        if (h_act && v_act) fb_addr <= addr_nxt;
        vld_pipe[1] <= h_act && v_act;
        hs1         <= hs_n;
        vs1         <= vs_n;
        // stage 2: RAM data lands here, aligned with the delayed syncs
        vld_pipe[2] <= vld_pipe[1];
        VGA_HS      <= hs1;
        VGA_VS      <= vs1;
        VGA_R       <= {10{vld_pipe[1] & fb_data[2]}};
        VGA_G       <= {10{vld_pipe[1] & fb_data[1]}};
        VGA_B       <= {10{vld_pipe[1] & fb_data[0]}};
      end
    end
  end

  assign fb_rd       = vld_pipe[1];
  assign VGA_BLANK_N = vld_pipe[2];
  assign VGA_SYNC_N  = 1'b0;
  assign VGA_CLK     = ph;

endmodule
